// File: rtl/td4_loader_pkg.sv
// Shared types and widths for the TD4 program loader.
package td4_loader_pkg;
  localparam int WORD_W = 8;
  localparam int OPC_W  = 4;
  localparam int IMM_W  = 4;

  typedef enum logic [2:0] {
    LOAD,
    CHECK,
    RELEASE,
    RUN,
    ERROR
  } state_t;
endpackage

// File: rtl/td4_prog_mem.sv
// TD4 program store: flop array, one synchronous write port, one combinational read port.
module td4_prog_mem
  import td4_loader_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][WORD_W-1:0] mem;

  always_ff @(posedge clk) begin
    if (reset)   mem <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  // No write-through: a byte written this cycle is visible from the next one.
  assign rdata = mem[raddr];
endmodule

// File: rtl/td4_program_loader.sv
// TD4 program memory + byte-stream loader; holds the core in reset while loading.
// Optional trailing checksum byte and ERROR state: TD4_LOADER_CHECKSUM_EN.
module td4_program_loader
  import td4_loader_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [WORD_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] Adr,
  output logic [OPC_W-1:0]  Instr,
  output logic [IMM_W-1:0]  Im,
  output logic              cpu_n_reset,
  output logic              loading,
  output logic              err
);
  state_t            state, next;
  logic [ADDR_W-1:0] ptr;
  logic [WORD_W-1:0] rdata;
  logic              accept;
  logic              restart;

  assign accept  = ld_valid & ld_ready;
  assign restart = ld_start & ((state == RUN) | (state == ERROR));
  assign loading = (state == LOAD) | (state == CHECK) | (state == RELEASE);

`ifdef TD4_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] csum;
`endif

  always_comb begin
    next     = state;
    ld_ready = 1'b0;
    case (state)
      LOAD: begin
        ld_ready = 1'b1;
        if (accept && (&ptr)) begin
`ifdef TD4_LOADER_CHECKSUM_EN
          next = CHECK;
`else
          next = RELEASE;
`endif
        end
      end
`ifdef TD4_LOADER_CHECKSUM_EN
      CHECK: begin
        ld_ready = 1'b1;
        if (accept) next = (ld_data == csum) ? RELEASE : ERROR;
      end
      ERROR:   if (ld_start) next = LOAD;
`endif
      RELEASE: next = RUN;
      RUN:     if (ld_start) next = LOAD;
      default: next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOAD;
      ptr         <= '0;
      cpu_n_reset <= 1'b0;
    end else begin
      state       <= next;
      cpu_n_reset <= (next == RUN);
      if (restart)                        ptr <= '0;
      else if (state == LOAD && accept)   ptr <= ptr + 1'b1;
    end
  end

`ifdef TD4_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      csum <= '0;
      err  <= 1'b0;
    end else begin
      err <= (next == ERROR);
      if (restart)                      csum <= '0;
      else if (state == LOAD && accept) csum <= csum + ld_data;
    end
  end
`else
  assign err = 1'b0;
`endif

  td4_prog_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (state == LOAD && accept),
    .waddr (ptr),
    .wdata (ld_data),
    .raddr (Adr),
    .rdata (rdata)
  );

  assign Instr = rdata[WORD_W-1 -: OPC_W];
  assign Im    = rdata[IMM_W-1:0];
endmodule

// File: tb/tb_td4_program_loader.sv
// Directed/randomized bench for td4_program_loader against an array-based program model.
module tb_td4_program_loader;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ld_start = 1'b0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = 8'h00;
  logic       ld_ready;
  logic [3:0] Adr = 4'h0;
  logic [3:0] Instr, Im;
  logic       cpu_n_reset, loading, err;

  int tests = 0;
  int fails = 0;
  logic [7:0] model [16];
  logic [7:0] img   [16];

  td4_program_loader #(.ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ld_ready), .Adr(Adr), .Instr(Instr), .Im(Im),
    .cpu_n_reset(cpu_n_reset), .loading(loading), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    for (int a = 0; a < 16; a++) begin
      Adr = 4'(a);
      #1;
      chk($sformatf("%s[%0d]", tag, a), {24'h0, Instr, Im}, {24'h0, model[a]});
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit done = 1'b0;
    if (gaps) begin
      ld_valid = 1'b0;
      repeat ($urandom_range(0, 3)) step();
    end
    ld_valid = 1'b1;
    ld_data  = b;
    for (int i = 0; i < 8 && !done; i++) begin
      if (ld_ready) done = 1'b1;
      step();
    end
    if (!done) chk("accept_timeout", 32'h0, 32'h1);
  endtask

  // Streams img[] (plus checksum when enabled); model[] follows the accepted bytes.
  task automatic load_image(input bit gaps, input bit bad_csum);
    logic [7:0] sum = 8'h00;
    for (int i = 0; i < 16; i++) begin
      send_byte(img[i], gaps);
      model[i] = img[i];
      sum = sum + img[i];
    end
`ifdef TD4_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? ~sum : sum, gaps);
`endif
    ld_valid = 1'b0;
    chk("release_nrst", {31'h0, cpu_n_reset}, 32'h0);
    chk("release_rdy", {31'h0, ld_ready}, 32'h0);
`ifdef TD4_LOADER_CHECKSUM_EN
    if (bad_csum) begin
      step();
      chk("error_err", {31'h0, err}, 32'h1);
      chk("error_nrst", {31'h0, cpu_n_reset}, 32'h0);
      return;
    end
`endif
    step();
    chk("run_nrst", {31'h0, cpu_n_reset}, 32'h1);
    chk("run_rdy", {31'h0, ld_ready}, 32'h0);
    chk("run_err", {31'h0, err}, 32'h0);
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
  endtask

  initial begin
    // Reset and post-reset state
    step();
    reset = 1'b0;
    chk("rst_rdy", {31'h0, ld_ready}, 32'h1);
    chk("rst_nrst", {31'h0, cpu_n_reset}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_loading", {31'h0, loading}, 32'h1);
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    chk_mem("rst_mem");

    // Back-to-back 0x30..0x3F
    for (int i = 0; i < 16; i++) img[i] = 8'h30 + 8'(i);
    load_image(1'b0, 1'b0);
    Adr = 4'd5;
    #1;
    chk("adr5_instr", {28'h0, Instr}, 32'h3);
    chk("adr5_im", {28'h0, Im}, 32'h5);
    chk_mem("seq_mem");

    // RUN ignores the stream
    ld_valid = 1'b1;
    ld_data  = 8'hFF;
    repeat (4) begin
      step();
      chk("run_ignore_rdy", {31'h0, ld_ready}, 32'h0);
    end
    ld_valid = 1'b0;
    chk_mem("run_ignore_mem");

    // ld_start in RUN: core held next cycle, old image still readable
    pulse_start();
    chk("restart_nrst", {31'h0, cpu_n_reset}, 32'h0);
    chk("restart_rdy", {31'h0, ld_ready}, 32'h1);
    chk_mem("restart_keep");

    // Random image with random gaps, plus an ignored ld_start mid-load
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      send_byte(img[i], 1'b1);
      model[i] = img[i];
    end
    ld_valid = 1'b0;
    pulse_start();
    chk("midload_start_rdy", {31'h0, ld_ready}, 32'h1);
    for (int i = 8; i < 16; i++) begin
      send_byte(img[i], 1'b1);
      model[i] = img[i];
    end
`ifdef TD4_LOADER_CHECKSUM_EN
    begin
      logic [7:0] s = 8'h00;
      for (int i = 0; i < 16; i++) s = s + img[i];
      send_byte(s, 1'b1);
    end
`endif
    ld_valid = 1'b0;
    chk("gap_release_nrst", {31'h0, cpu_n_reset}, 32'h0);
    step();
    chk("gap_run_nrst", {31'h0, cpu_n_reset}, 32'h1);
    chk_mem("gap_mem");

    // Partial load then reset: memory cleared, pointer restarts at 0
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i), 1'b0);
    ld_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    chk("midrst_nrst", {31'h0, cpu_n_reset}, 32'h0);
    chk_mem("midrst_mem");
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
    load_image(1'b1, 1'b0);
    chk_mem("after_rst_mem");

`ifdef TD4_LOADER_CHECKSUM_EN
    // Wrong checksum: ERROR holds, ld_start recovers
    pulse_start();
    for (int i = 0; i < 16; i++) img[i] = 8'h30 + 8'(i);
    load_image(1'b0, 1'b1);
    repeat (3) begin
      step();
      chk("err_hold", {31'h0, err}, 32'h1);
      chk("err_nrst", {31'h0, cpu_n_reset}, 32'h0);
      chk("err_rdy", {31'h0, ld_ready}, 32'h0);
    end
    pulse_start();
    chk("err_clear", {31'h0, err}, 32'h0);
    chk("err_reload_rdy", {31'h0, ld_ready}, 32'h1);
    load_image(1'b0, 1'b0);
    chk_mem("err_reload_mem");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
